// File: rtl/ntt_mem_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for NTT BRAM clients.
// Imported by bram_stream_reader and its sub-modules.
package ntt_mem_pkg;

  localparam int BRAM_DW = 36;
  localparam int BRAM_AW = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reverse the low nbits bits of value; upper bits come back zero.
  function automatic logic [15:0] bitrev(
    input logic [15:0] value,
    input logic [3:0]  nbits
  );
    logic [15:0] r;
    logic [3:0]  j;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(nbits)) begin
        j    = nbits - 4'd1 - 4'(i);
        r[j] = value[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// Small register FIFO, first-word-fall-through (dout_o is the head entry).
// Ports: clk, rst (async high), push_i/din_i, pop_i, dout_o, count_o.
module sync_fifo_small
  import ntt_mem_pkg::*;
#(
  parameter int DW    = BRAM_DW,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i) rd_q <= inc(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps an address range of a registered-read BRAM and streams it out (valid/ready).
// Ports: clk, rst, start/base_addr/length, busy, done, rd_addr/rd_dout, m_data/m_valid/m_ready.
// Optional macro BITREV_RD_EN adds bitrev/log_len inputs for bit-reversed read order.
module bram_stream_reader
  import ntt_mem_pkg::*;
#(
  parameter int DW         = BRAM_DW,
  parameter int AW         = BRAM_AW,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
`ifdef BITREV_RD_EN
  input  logic          bitrev,
  input  logic [3:0]    log_len,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW:0]   len_q;
  logic [AW:0]   issue_cnt_q;
  logic [AW:0]   pop_cnt_q;
  logic          inflight_q;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occ;
  logic [AW-1:0] offs;
  logic          accept;
  logic          pop;
  logic          issue;
  logic          last_pop;

`ifdef BITREV_RD_EN
  logic          brev_q;
  logic [3:0]    lg_q;
`endif

  assign accept = (state_q == IDLE) && start;
  assign pop    = m_valid & m_ready;

  // Words held or on their way: a pop this cycle frees one slot early.
  assign occ   = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
  assign issue = (state_q == RUN)
              && (issue_cnt_q < len_q)
              && (occ < (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));

  assign last_pop = (state_q == RUN) && pop
                 && (pop_cnt_q == len_q - (AW+1)'(1));

`ifdef BITREV_RD_EN
  assign offs = brev_q
    ? AW'(ntt_mem_pkg::bitrev(16'(issue_cnt_q[AW-1:0]), lg_q))
    : issue_cnt_q[AW-1:0];
`else
  assign offs = issue_cnt_q[AW-1:0];
`endif

  // Address only moves on an issue; otherwise the last one is held.
  assign rd_addr = issue ? base_q + offs : rd_addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (length == '0) ? DONE : RUN;
      RUN:  if (last_pop) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      rd_addr_q  <= rd_addr;
      if (accept) begin
        base_q      <= base_addr;
        len_q       <= length;
        issue_cnt_q <= '0;
        pop_cnt_q   <= '0;
      end else begin
        if (issue) issue_cnt_q <= issue_cnt_q + (AW+1)'(1);
        if (pop && state_q == RUN) pop_cnt_q <= pop_cnt_q + (AW+1)'(1);
      end
    end
  end

`ifdef BITREV_RD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brev_q <= 1'b0;
      lg_q   <= '0;
    end else if (accept) begin
      brev_q <= bitrev;
      lg_q   <= log_len;
    end
  end
`endif

  // The read issued last cycle lands on rd_dout now.
  sync_fifo_small #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (rd_dout),
    .pop_i   (pop),
    .dout_o  (m_data),
    .count_o (fifo_cnt)
  );

  assign m_valid = (fifo_cnt != '0);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule
